// File: rtl/snn_pkg.sv
// Shared constants and types for the spiking-neuron datapath.
// Used by the charge scanner and its lane priority encoder.
package snn_pkg;

  localparam int N_NEURONS   = 256;
  localparam int LANES       = 4;
  localparam int CHARGE_W    = 8;
  localparam int WORD_ADDR_W = 6;

  typedef logic signed [CHARGE_W-1:0] charge_t;
  typedef logic [7:0] neuron_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } scan_state_e;

endpackage

// File: rtl/lane_priority_enc.sv
// Lowest-set-bit encoder over a lane mask.
// Ports: mask_i lane mask; idx_o lowest set lane; any_o mask nonzero.
module lane_priority_enc #(
  parameter int LANES = 4,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic [LANES-1:0] mask_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |mask_i;
    // scan downward so the lowest set lane is written last
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/charge_fire_scanner.sv
// Walks the charge array, thresholds each lane and streams spikes.
// Ports: CLK/RSTN, start_i/threshold_i, count_o/synapse_charge_i read port,
// spike_valid_o/spike_ready_i/spike_addr_o stream, busy_o, done_o, fire_cnt_o.
module charge_fire_scanner
  import snn_pkg::*;
#(
  parameter int N        = N_NEURONS,
  parameter int LANES    = snn_pkg::LANES,
  parameter int CHARGE_W = snn_pkg::CHARGE_W,
  parameter int ADDR_W   = WORD_ADDR_W
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      start_i,
  input  charge_t                   threshold_i,
  output logic [ADDR_W-1:0]         count_o,
  input  logic [LANES*CHARGE_W-1:0] synapse_charge_i,
  output logic                      spike_valid_o,
  input  logic                      spike_ready_i,
  output neuron_addr_t              spike_addr_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [8:0]                fire_cnt_o
);

  localparam int IDX_W = $clog2(LANES);
  localparam int CNT_W = 9;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N / LANES - 1);

  scan_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  count_q, count_d;
  charge_t            thr_q, thr_d;
  logic [LANES-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]   fire_q, fire_d;

  logic [LANES-1:0]   hit;
  logic [LANES-1:0]   rest;
  logic [IDX_W-1:0]   pend_idx;
  logic               pend_any;
  logic               last_word;

  lane_priority_enc #(
    .LANES (LANES),
    .IDX_W (IDX_W)
  ) u_enc (
    .mask_i (pend_q),
    .idx_o  (pend_idx),
    .any_o  (pend_any)
  );

  always_comb begin
    hit = '0;
    for (int k = 0; k < LANES; k++) begin
      hit[k] = $signed(synapse_charge_i[k*CHARGE_W +: CHARGE_W])
               >= $signed(thr_q);
    end
  end

  // pending mask once the currently presented lane is accepted
  assign rest      = pend_q & ~(LANES'(1) << pend_idx);
  assign last_word = (count_q == LAST_WORD);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    thr_d   = thr_q;
    pend_d  = pend_q;
    fire_d  = fire_q;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (start_i) begin
          thr_d   = threshold_i;
          fire_d  = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        pend_d = hit;
        if (hit != '0) begin
          state_d = EMIT;
        end else if (last_word) begin
          state_d = DONE;
          count_d = '0;
        end else begin
          count_d = count_q + ADDR_W'(1);
        end
      end
      EMIT: begin
        if (spike_ready_i) begin
          pend_d = rest;
          fire_d = fire_q + CNT_W'(1);
          if (rest == '0) begin
            if (last_word) begin
              state_d = DONE;
              count_d = '0;
            end else begin
              state_d = SCAN;
              count_d = count_q + ADDR_W'(1);
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        count_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      count_q <= '0;
      thr_q   <= '0;
      pend_q  <= '0;
      fire_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      thr_q   <= thr_d;
      pend_q  <= pend_d;
      fire_q  <= fire_d;
    end
  end

  assign count_o       = count_q;
  assign spike_valid_o = (state_q == EMIT) && pend_any;
  assign spike_addr_o  = {count_q, pend_idx};
  assign busy_o        = (state_q == SCAN) || (state_q == EMIT);
  assign done_o        = (state_q == DONE);
  assign fire_cnt_o    = fire_q;

endmodule

// File: tb/tb_charge_fire_scanner.sv
// Directed and randomized bench for charge_fire_scanner.
// Models the charge array and predicts the spike list from the threshold rule.
module tb_charge_fire_scanner;

  logic              CLK = 1'b0;
  logic              RSTN;
  logic              start_i;
  logic signed [7:0] threshold_i;
  logic [5:0]        count_o;
  logic [31:0]       synapse_charge_i;
  logic              spike_valid_o;
  logic              spike_ready_i;
  logic [7:0]        spike_addr_o;
  logic              busy_o;
  logic              done_o;
  logic [8:0]        fire_cnt_o;

  logic signed [7:0] mem [256];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  charge_fire_scanner dut (
    .CLK              (CLK),
    .RSTN             (RSTN),
    .start_i          (start_i),
    .threshold_i      (threshold_i),
    .count_o          (count_o),
    .synapse_charge_i (synapse_charge_i),
    .spike_valid_o    (spike_valid_o),
    .spike_ready_i    (spike_ready_i),
    .spike_addr_o     (spike_addr_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .fire_cnt_o       (fire_cnt_o)
  );

  always_comb begin
    synapse_charge_i = '0;
    for (int k = 0; k < 4; k++)
      synapse_charge_i[k*8 +: 8] = mem[int'(count_o) * 4 + k];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_count"}, 32'(count_o), 0);
    chk({tag, "_valid"}, 32'(spike_valid_o), 0);
    chk({tag, "_addr"}, 32'(spike_addr_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_fire"}, 32'(fire_cnt_o), 0);
  endtask

  // rmode 0: ready high; 1: random ready; 2: ready low for 7 offered cycles
  task automatic run_scan(input logic signed [7:0] thr,
                          input int rmode,
                          input bit poke_start);
    int q[$];
    int hits;
    int stalls   = 0;
    int cyc      = 0;
    int low_left = 7;
    bit fin      = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] >= thr) q.push_back(i);
    hits = q.size();
    @(negedge CLK);
    start_i     = 1'b1;
    threshold_i = thr;
    @(negedge CLK);
    start_i     = 1'b0;
    threshold_i = 8'($urandom);
    chk("busy_at_entry", 32'(busy_o), 1);
    chk("fire_cleared", 32'(fire_cnt_o), 0);
    while (!fin) begin
      case (rmode)
        0: spike_ready_i = 1'b1;
        1: spike_ready_i = ($urandom_range(0, 3) != 0);
        default: spike_ready_i = (low_left == 0);
      endcase
      start_i = poke_start && (cyc == 10);
      if (start_i) threshold_i = ~thr;
      if (done_o) begin
        fin = 1;
      end else if (spike_valid_o) begin
        if (q.size() == 0) begin
          chk("extra_spike", 32'(spike_addr_o), 32'hffff_ffff);
        end else begin
          chk("spike_addr", 32'(spike_addr_o), 32'(q[0]));
          chk("emit_count", 32'(count_o), 32'(q[0] >> 2));
          if (spike_ready_i) begin
            void'(q.pop_front());
          end else begin
            stalls++;
            if (low_left > 0) low_left--;
          end
        end
      end else if (hits == 0) begin
        chk("count_sweep", 32'(count_o), 32'(cyc));
      end
      if (!fin) begin
        @(negedge CLK);
        cyc++;
        if (cyc > 2000) begin
          chk("timeout", 32'(cyc), 0);
          fin = 1;
        end
      end
    end
    start_i       = 1'b0;
    spike_ready_i = 1'b1;
    chk("done_cycle", 32'(cyc), 32'(64 + hits + stalls));
    chk("fire_cnt", 32'(fire_cnt_o), 32'(hits));
    chk("missing_spikes", 32'(q.size()), 0);
    chk("busy_in_done", 32'(busy_o), 0);
    chk("count_in_done", 32'(count_o), 0);
    @(negedge CLK);
    chk("done_pulse", 32'(done_o), 0);
    chk("fire_hold", 32'(fire_cnt_o), 32'(hits));
  endtask

  initial begin
    RSTN          = 1'b0;
    start_i       = 1'b0;
    threshold_i   = '0;
    spike_ready_i = 1'b1;
    clear_mem();
    repeat (2) @(negedge CLK);
    check_idle("reset");
    RSTN = 1'b1;

    run_scan(8'sd1, 0, 0);

    mem[20] = 8'sd9;
    mem[21] = 8'sd10;
    mem[22] = -8'sd3;
    mem[23] = 8'sd10;
    run_scan(8'sd10, 0, 0);

    clear_mem();
    run_scan(-8'sd128, 0, 0);

    mem[2] = 8'sd5;
    run_scan(8'sd5, 2, 0);

    clear_mem();
    mem[255] = 8'sd127;
    mem[254] = 8'sd126;
    run_scan(8'sd127, 0, 0);

    clear_mem();
    mem[100] = 8'sd50;
    run_scan(8'sd40, 1, 1);

    // reset while spikes are pending and stalled
    clear_mem();
    spike_ready_i = 1'b0;
    @(negedge CLK);
    start_i     = 1'b1;
    threshold_i = -8'sd128;
    @(negedge CLK);
    start_i = 1'b0;
    for (int i = 0; i < 10 && !spike_valid_o; i++) @(negedge CLK);
    chk("pre_reset_valid", 32'(spike_valid_o), 1);
    RSTN = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    check_idle("mid_reset");
    spike_ready_i = 1'b1;
    @(negedge CLK);
    check_idle("post_reset");

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      run_scan(8'($urandom_range(0, 255)), 1, (t == 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/charge_fire_scanner.md
Name: charge_fire_scanner

Overview:
- Reader for the neuron charge array held by the charge accumulator.
- On `start_i`, walks all word addresses 0..N/4-1 on `count_o` and samples the returned 32-bit word, which packs four signed 8-bit charges.
- Compares each charge against a signed threshold and emits one spike event per firing neuron over a valid/ready stream, in ascending neuron index order.
- Sits between the charge accumulator and the spike/AER output logic.

Parameters:
- N, 256, number of neurons; must be a multiple of LANES.
- LANES, 4, charges per read word; fixed by the 32-bit read bus.
- CHARGE_W, 8, bits per signed charge.
- ADDR_W, 6, word address width; equals log2(N/LANES).

Ports:
- CLK  in  1  clock.
- RSTN  in  1  synchronous active-low reset.
- start_i  in  1  scan request pulse; accepted only in IDLE.
- threshold_i  in  8  signed firing threshold; sampled at start accept.
- count_o  out  ADDR_W  word address driven to the charge array read port.
- synapse_charge_i  in  32  read data; lane k is at bits [8k+7:8k]; combinational from count_o, valid in the same cycle.
- spike_valid_o  out  1  spike event valid.
- spike_ready_i  in  1  downstream accepts event.
- spike_addr_o  out  8  neuron index = count_o*4 + lane.
- busy_o  out  1  high from start accept until done.
- done_o  out  1  one-cycle pulse when the scan completes.
- fire_cnt_o  out  9  spikes emitted in the last or current scan (0..256).

Behaviour:
- Reset: all outputs and state are 0 on any CLK edge with RSTN=0. This includes a reset mid-scan: the FSM returns to IDLE, any pending spike is dropped, and `fire_cnt_o` is cleared.
- FSM states: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - `count_o` = 0.
  - On `start_i`: latch `threshold_i` into `thr_q`, clear `fire_cnt_o`, set `busy_o`, go to SCAN.
  - `start_i` in any other state is ignored.
- SCAN (one cycle per word):
  - Compute `hit[k] = ($signed(lane_k) >= $signed(thr_q))`. Equality fires.
  - Register `hit` into `pend_q` and the word into a holding register.
  - If `hit == 0`: if `count_o` is the last word, go to DONE; otherwise increment `count_o` and stay in SCAN.
  - If `hit != 0`: go to EMIT; `count_o` holds.
- EMIT:
  - `spike_valid_o = 1`; `spike_addr_o = {count_o, lowest set lane of pend_q}`.
  - Valid and addr stay stable until handshake (`valid & ready`).
  - On each handshake: clear that `pend_q` bit and increment `fire_cnt_o`.
  - When the last pending bit is accepted in a cycle: `spike_valid_o` drops the next cycle. If `count_o` is the last word, go to DONE; otherwise increment `count_o` and go to SCAN.
  - No bubble between spikes of the same word: throughput is one spike per cycle with `ready` held high.
- DONE: one cycle; `done_o = 1`, `busy_o` drops to 0, `count_o` returns to 0, next state IDLE. `fire_cnt_o` holds until the next start.
- Latency:
  - Word with no hits: 1 cycle.
  - Word with h hits and `ready` always high: 1 + h cycles.
  - Full scan, no spikes: N/4 cycles from SCAN entry to DONE.
- Data source: charge data is sampled only in SCAN. The scanner never writes the array. Accumulation while busy is a system-level error, and the data is then undefined for this block.
- Width: the compare is signed 8-bit; no extension beyond sign. `fire_cnt_o` cannot overflow (max N = 256 fits in 9 bits).
- Wrap-around: `count_o` never wraps past N/4-1 within a scan.

Decomposition:
- Shared package `snn_pkg`:
  - constants `N_NEURONS`, `LANES`, `CHARGE_W`, `WORD_ADDR_W`;
  - typedef `charge_t` (logic signed [7:0]);
  - typedef `neuron_addr_t` ([7:0]);
  - enum `scan_state_e` {IDLE, SCAN, EMIT, DONE}.
- One sub-module: `lane_priority_enc` (LANES-bit mask -> lowest set index + any flag). Used for the EMIT address and next-mask computation.

Test Plan:
- All charges 0, `threshold` = 1, start -> no `spike_valid_o`; `done_o` pulses exactly 64 cycles after SCAN entry; `fire_cnt_o` = 0; `count_o` sweeps 0..63 then 0.
- Word 5 = {lane3=10, lane2=-3, lane1=10, lane0=9}, all others 0, `threshold` = 10, `ready` = 1 -> spikes addr 21 then 23 on consecutive cycles; `fire_cnt_o` = 2.
- `threshold` = -128, all charges 0 -> 256 spikes, addr 0..255 in order; `fire_cnt_o` = 256; scan takes 64 + 256 cycles.
- Backpressure: `threshold` = 5, charge[2] = 5, `ready` low for 7 cycles -> valid held with addr 2 stable for 7 cycles; accepted on cycle 8; `count_o` holds at 0 throughout.
- Reset mid-EMIT and `start_i` during busy -> after RSTN=0 for one edge, all outputs are 0 and state is IDLE; a start pulsed during an active scan does not restart it and `fire_cnt_o` is unaffected.
- Boundary: `threshold` = 127, charge[255] = 127, charge[254] = 126 -> exactly one spike, addr 255; `done_o` follows the handshake by one cycle.
